// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, parity modes and the
// half-bit sample counter reload.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Loaded on start detection so every later sample lands mid-bit.
  function automatic int half_bit(input int oversample);
    return oversample / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// CPU-side bus of the UART receiver: FIFO head, pop, sticky errors and irq.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                            rd_en;
  logic                            err_clr;
  logic [DATA_BITS-1:0]            d_out;
  logic                            rx_valid;
  logic [$clog2(FIFO_DEPTH):0]     fifo_count;
  logic                            err_frame;
  logic                            err_parity;
  logic                            err_overrun;
  logic                            irq;

  modport master (
    input  rd_en, err_clr,
    output d_out, rx_valid, fifo_count, err_frame, err_parity, err_overrun, irq
  );

  modport slave (
    output rd_en, err_clr,
    input  d_out, rx_valid, fifo_count, err_frame, err_parity, err_overrun, irq
  );
endinterface

// File: rtl/sync_fifo.sv
// Purpose: first-word-fall-through FIFO, head visible on rd_dat (0 when empty).
// Latency: a push is visible on rd_dat/count right after its clock edge.
// Backpressure: push when full is dropped unless a pop frees the slot that cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_dat  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// Purpose: oversampling UART receiver feeding a FWFT FIFO with sticky errors.
// Latency: byte pushed on the last stop-bit sample edge; irq pulses the next cycle.
// Backpressure: none on rxd; a frame completing into a full FIFO without a pop is dropped as overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_rx,
  input  logic              rxd,
  uart_rx_fifo_if.master    bus
);
  localparam int CW    = $clog2(OVERSAMPLE);
  localparam int BW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                 rxd_m, rxd_s;
  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic                 stop_cnt, stop_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bad, par_bad_n;
  logic                 push, set_frame, set_par, set_ovr;
  logic                 sample, par_exp;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_dat;
  logic [CNT_W-1:0]     fifo_cnt;
  logic                 err_frame_q, err_parity_q, err_overrun_q, irq_q;

  assign sample  = en_rx && (cnt == '0);
  assign par_exp = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m         <= 1'b1;
      rxd_s         <= 1'b1;
      state         <= ST_IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      stop_cnt      <= 1'b0;
      shreg         <= '0;
      par_bad       <= 1'b0;
      err_frame_q   <= 1'b0;
      err_parity_q  <= 1'b0;
      err_overrun_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      rxd_m         <= rxd;
      rxd_s         <= rxd_m;
      state         <= state_n;
      cnt           <= cnt_n;
      bit_cnt       <= bit_n;
      stop_cnt      <= stop_n;
      shreg         <= shreg_n;
      par_bad       <= par_bad_n;
      // A new event wins over a simultaneous clear.
      err_frame_q   <= (err_frame_q   && !bus.err_clr) || set_frame;
      err_parity_q  <= (err_parity_q  && !bus.err_clr) || set_par;
      err_overrun_q <= (err_overrun_q && !bus.err_clr) || set_ovr;
      irq_q         <= push;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_cnt;
    stop_n    = stop_cnt;
    shreg_n   = shreg;
    par_bad_n = par_bad;
    push      = 1'b0;
    set_frame = 1'b0;
    set_par   = 1'b0;
    set_ovr   = 1'b0;
    if (en_rx) cnt_n = (cnt == '0) ? CW'(OVERSAMPLE - 1) : cnt - 1'b1;
    case (state)
      ST_IDLE: if (en_rx && !rxd_s) begin
        state_n = ST_START;
        cnt_n   = CW'(half_bit(OVERSAMPLE));
      end
      ST_START: if (sample) begin
        if (rxd_s) state_n = ST_IDLE;
        else begin
          state_n   = ST_DATA;
          bit_n     = BW'(DATA_BITS - 1);
          par_bad_n = 1'b0;
        end
      end
      ST_DATA: if (sample) begin
        shreg_n = {rxd_s, shreg[DATA_BITS-1:1]};
        if (bit_cnt == '0) begin
          state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          stop_n  = 1'(STOP_BITS - 1);
        end else begin
          bit_n = bit_cnt - 1'b1;
        end
      end
      ST_PARITY: if (sample) begin
        par_bad_n = (rxd_s != par_exp);
        state_n   = ST_STOP;
        stop_n    = 1'(STOP_BITS - 1);
      end
      ST_STOP: if (sample) begin
        if (!rxd_s) begin
          set_frame = 1'b1;
          state_n   = ST_WAIT_IDLE;
        end else if (stop_cnt != 1'b0) begin
          stop_n = 1'b0;
        end else begin
          if (par_bad)                        set_par = 1'b1;
          else if (fifo_full && !bus.rd_en)   set_ovr = 1'b1;
          else                                push    = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_WAIT_IDLE: if (en_rx && rxd_s) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wr_dat (shreg_n),
    .pop    (bus.rd_en),
    .rd_dat (fifo_dat),
    .count  (fifo_cnt),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bus.d_out       = fifo_dat;
  assign bus.rx_valid    = !fifo_empty;
  assign bus.fifo_count  = fifo_cnt;
  assign bus.err_frame   = err_frame_q;
  assign bus.err_parity  = err_parity_q;
  assign bus.err_overrun = err_overrun_q;
  assign bus.irq         = irq_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 and an 8E1 instance checked against a frame-level FIFO model.
module tb_uart_rx_fifo;
  localparam int OS = 8;
  localparam int DB = 8;
  localparam int DEPTH = 4;
  localparam int K_OK = 0, K_FRAME = 1, K_PAR = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic en_rx;
  logic rxd_v [2];
  logic rd_en_v [2];
  logic err_clr_v [2];
  logic [7:0] dout_v [2];
  logic       valid_v [2];
  logic [2:0] count_v [2];
  logic       efr_v [2], epa_v [2], eov_v [2], irq_v [2];

  uart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus0 ();
  uart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus1 ();

  uart_rx_fifo #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
    dut0 (.clk(clk), .rst_n(rst_n), .en_rx(en_rx), .rxd(rxd_v[0]), .bus(bus0));
  uart_rx_fifo #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
    dut1 (.clk(clk), .rst_n(rst_n), .en_rx(en_rx), .rxd(rxd_v[1]), .bus(bus1));

  assign bus0.rd_en = rd_en_v[0];
  assign bus0.err_clr = err_clr_v[0];
  assign bus1.rd_en = rd_en_v[1];
  assign bus1.err_clr = err_clr_v[1];
  assign dout_v[0] = bus0.d_out;       assign dout_v[1] = bus1.d_out;
  assign valid_v[0] = bus0.rx_valid;   assign valid_v[1] = bus1.rx_valid;
  assign count_v[0] = bus0.fifo_count; assign count_v[1] = bus1.fifo_count;
  assign efr_v[0] = bus0.err_frame;    assign efr_v[1] = bus1.err_frame;
  assign epa_v[0] = bus0.err_parity;   assign epa_v[1] = bus1.err_parity;
  assign eov_v[0] = bus0.err_overrun;  assign eov_v[1] = bus1.err_overrun;
  assign irq_v[0] = bus0.irq;          assign irq_v[1] = bus1.irq;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: each instance is a byte queue plus three sticky flags and an irq bit.
  // A frame's outcome is scheduled for the edge where its last stop bit is sampled.
  logic [7:0] mq [2][$];
  bit m_fr [2], m_pa [2], m_ov [2], m_irq [2];
  int pend_cyc [2];
  int pend_kind [2];
  logic [7:0] pend_dat [2];
  bit mp_push, mp_fr, mp_pa, mp_ov;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        mq[u].delete();
        m_fr[u] = 0; m_pa[u] = 0; m_ov[u] = 0; m_irq[u] = 0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        mp_push = 0; mp_fr = 0; mp_pa = 0; mp_ov = 0;
        if (pend_cyc[u] == cyc + 1) begin
          if (pend_kind[u] == K_FRAME) mp_fr = 1;
          else if (pend_kind[u] == K_PAR) mp_pa = 1;
          else if (mq[u].size() == DEPTH && !rd_en_v[u]) mp_ov = 1;
          else mp_push = 1;
        end
        if (rd_en_v[u] && mq[u].size() > 0) void'(mq[u].pop_front());
        if (mp_push) mq[u].push_back(pend_dat[u]);
        m_fr[u] = (m_fr[u] && !err_clr_v[u]) || mp_fr;
        m_pa[u] = (m_pa[u] && !err_clr_v[u]) || mp_pa;
        m_ov[u] = (m_ov[u] && !err_clr_v[u]) || mp_ov;
        m_irq[u] = mp_push;
      end
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d d_out", u), dout_v[u], (mq[u].size() > 0) ? mq[u][0] : 8'h00);
      chk($sformatf("u%0d rx_valid", u), valid_v[u], mq[u].size() > 0);
      chk($sformatf("u%0d fifo_count", u), count_v[u], mq[u].size());
      chk($sformatf("u%0d err_frame", u), efr_v[u], m_fr[u]);
      chk($sformatf("u%0d err_parity", u), epa_v[u], m_pa[u]);
      chk($sformatf("u%0d err_overrun", u), eov_v[u], m_ov[u]);
      chk($sformatf("u%0d irq", u), irq_v[u], m_irq[u]);
    end
  end

  // Called just after a clock edge. Drives one frame; optionally pops on the
  // push edge, or pulses reset at cycle abort_c of the frame.
  task automatic send(input int u, input logic [7:0] dat, input logic pbit,
                      input logic stop, input bit pop, input int abort_c);
    logic [15:0] fb;
    int nb, e0;
    bit haspar;
    haspar = (u == 1);
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < DB; i++) fb[1+i] = dat[i];
    nb = DB;
    if (haspar) begin nb++; fb[nb] = pbit; end
    nb++;
    fb[nb] = stop;
    e0 = cyc;
    pend_dat[u] = dat;
    pend_kind[u] = !stop ? K_FRAME : (haspar && (pbit != ^dat)) ? K_PAR : K_OK;
    pend_cyc[u] = e0 + 3 + OS/2 + nb*OS;
    for (int c = 0; c < (nb + 3) * OS; c++) begin
      if (c == abort_c) begin
        rxd_v[u] = 1'b1;
        pend_cyc[u] = -1;
        rst_n = 1'b0;
        #1;
        chk("async reset d_out", dout_v[u], 0);
        chk("async reset rx_valid", valid_v[u], 0);
        chk("async reset fifo_count", count_v[u], 0);
        chk("async reset err_frame", efr_v[u], 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        break;
      end
      rxd_v[u] = (c / OS <= nb) ? fb[c / OS] : 1'b1;
      rd_en_v[u] = pop && (e0 + c + 1 == pend_cyc[u]);
      @(posedge clk); #1;
    end
    rd_en_v[u] = 1'b0;
  endtask

  task automatic pop1(input int u);
    rd_en_v[u] = 1'b1;
    @(posedge clk); #1;
    rd_en_v[u] = 1'b0;
  endtask

  task automatic clr(input int u);
    err_clr_v[u] = 1'b1;
    @(posedge clk); #1;
    err_clr_v[u] = 1'b0;
  endtask

  task automatic glitch(input int u);
    rxd_v[u] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rxd_v[u] = 1'b1;
    repeat (3 * OS) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en_rx = 1'b1;
    for (int u = 0; u < 2; u++) begin
      rxd_v[u] = 1'b1; rd_en_v[u] = 1'b0; err_clr_v[u] = 1'b0;
      pend_cyc[u] = -1; pend_kind[u] = K_OK; pend_dat[u] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset d_out", bus0.d_out, 0);
    chk("reset rx_valid", bus0.rx_valid, 0);
    chk("reset fifo_count", bus0.fifo_count, 0);
    chk("reset irq", bus0.irq, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    send(0, 8'hA5, 1'b0, 1'b1, 0, -1);
    chk("A5 d_out", bus0.d_out, 8'hA5);
    chk("A5 rx_valid", bus0.rx_valid, 1);
    chk("A5 fifo_count", bus0.fifo_count, 1);
    pop1(0);
    chk("A5 popped rx_valid", bus0.rx_valid, 0);
    chk("A5 popped d_out", bus0.d_out, 0);

    glitch(0);
    chk("glitch fifo_count", bus0.fifo_count, 0);
    chk("glitch err_frame", bus0.err_frame, 0);

    send(0, 8'h3C, 1'b0, 1'b0, 0, -1);
    chk("3C err_frame", bus0.err_frame, 1);
    chk("3C fifo_count", bus0.fifo_count, 0);
    send(0, 8'h55, 1'b0, 1'b1, 0, -1);
    chk("55 d_out", bus0.d_out, 8'h55);
    clr(0);
    chk("err_clr err_frame", bus0.err_frame, 0);
    pop1(0);

    send(1, 8'h07, 1'b0, 1'b1, 0, -1);
    chk("07 bad parity err_parity", bus1.err_parity, 1);
    chk("07 bad parity fifo_count", bus1.fifo_count, 0);
    send(1, 8'h07, 1'b1, 1'b1, 0, -1);
    chk("07 good parity d_out", bus1.d_out, 8'h07);
    chk("07 sticky err_parity", bus1.err_parity, 1);
    clr(1);
    chk("err_clr err_parity", bus1.err_parity, 0);

    for (int k = 1; k <= 4; k++) send(0, 8'(k), 1'b0, 1'b1, 0, -1);
    chk("full fifo_count", bus0.fifo_count, 4);
    send(0, 8'h05, 1'b0, 1'b1, 0, -1);
    chk("05 err_overrun", bus0.err_overrun, 1);
    chk("05 fifo_count", bus0.fifo_count, 4);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("pop order %0d", k), bus0.d_out, k);
      pop1(0);
    end
    chk("drained fifo_count", bus0.fifo_count, 0);
    for (int k = 1; k <= 4; k++) send(0, 8'(k), 1'b0, 1'b1, 0, -1);
    clr(0);
    send(0, 8'h06, 1'b0, 1'b1, 1, -1);
    chk("06 pop+push fifo_count", bus0.fifo_count, 4);
    chk("06 pop+push err_overrun", bus0.err_overrun, 0);
    chk("06 pop+push head", bus0.d_out, 8'h02);

    send(0, 8'h81, 1'b0, 1'b0, 0, -1);
    chk("pre-reset err_frame", bus0.err_frame, 1);
    send(0, 8'h99, 1'b0, 1'b1, 0, 4 * OS + 4);
    repeat (2 * OS) @(posedge clk);
    #1;
    send(0, 8'hC3, 1'b0, 1'b1, 0, -1);
    chk("C3 d_out", bus0.d_out, 8'hC3);
    chk("C3 fifo_count", bus0.fifo_count, 1);

    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
